// File: rtl/msrh_fpu_wb_merge.sv
// FPU writeback merge: folds the fixed-latency short path (FMV/FSGNJ) and the
// in-order, untagged fpnew long path onto one register write port and one
// done port. Long-path tags are queued at issue; losing short results wait in
// a small collision buffer. A flush converts queued tags into a discard count
// so that results still inside fpnew are dropped silently.
module msrh_fpu_wb_merge #(
   parameter int unsigned XLEN          = 64,
   parameter int unsigned RNID_W        = 7,
   parameter int unsigned RV_ENTRY_SIZE = 32,
   parameter int unsigned LONG_DEPTH    = 8,
   parameter int unsigned BUF_DEPTH     = 4
) (
   input  logic                     i_clk,
   input  logic                     i_reset,
   input  logic                     i_short_valid,
   input  logic                     i_short_wr,
   input  logic [RNID_W-1:0]        i_short_rnid,
   input  logic [RV_ENTRY_SIZE-1:0] i_short_index,
   input  logic [XLEN-1:0]          i_short_data,
   input  logic                     i_long_issue_valid,
   input  logic                     i_long_issue_wr,
   input  logic [RNID_W-1:0]        i_long_issue_rnid,
   input  logic [RV_ENTRY_SIZE-1:0] i_long_issue_index,
   input  logic                     i_long_res_valid,
   input  logic [XLEN-1:0]          i_long_res_data,
   input  logic [4:0]               i_long_res_fflags,
   input  logic                     i_flush,
   output logic                     o_stall,
   output logic                     o_wr_valid,
   output logic [RNID_W-1:0]        o_wr_rnid,
   output logic [XLEN-1:0]          o_wr_data,
   output logic                     o_done,
   output logic [RV_ENTRY_SIZE-1:0] o_done_index,
   output logic                     o_fflags_valid,
   output logic [4:0]               o_fflags,
   output logic                     o_err_overflow,
   output logic                     o_err_underflow
);

   localparam int unsigned LPTR_W   = $clog2(LONG_DEPTH);
   localparam int unsigned BPTR_W   = $clog2(BUF_DEPTH);
   localparam int unsigned LCNT_W   = LPTR_W + 1;
   localparam int unsigned BCNT_W   = BPTR_W + 1;
   // Discard headroom: one full tag FIFO beyond what a single flush can add.
   localparam int unsigned DISC_W   = $clog2(2 * LONG_DEPTH);
   localparam int unsigned DISC_MAX = 2 * LONG_DEPTH - 1;

   typedef struct packed {
      logic                     wr;
      logic [RNID_W-1:0]        rnid;
      logic [RV_ENTRY_SIZE-1:0] index;
   } tag_t;

   typedef struct packed {
      logic                     wr;
      logic [RNID_W-1:0]        rnid;
      logic [RV_ENTRY_SIZE-1:0] index;
      logic [XLEN-1:0]          data;
   } ent_t;

   // Storage (no reset needed: validity is carried by the counts)
   tag_t tag_mem_q [LONG_DEPTH];
   ent_t buf_mem_q [BUF_DEPTH];

   logic [LPTR_W-1:0] tag_rp_q, tag_rp_d, tag_wp_q, tag_wp_d;
   logic [LCNT_W-1:0] tag_cnt_q, tag_cnt_d;
   logic [BPTR_W-1:0] buf_rp_q, buf_rp_d, buf_wp_q, buf_wp_d;
   logic [BCNT_W-1:0] buf_cnt_q, buf_cnt_d;
   logic [DISC_W-1:0] disc_q, disc_d;
   logic [DISC_W:0]   disc_sum;

   logic                     wr_valid_q, wr_valid_d;
   logic [RNID_W-1:0]        wr_rnid_q, wr_rnid_d;
   logic [XLEN-1:0]          wr_data_q, wr_data_d;
   logic                     done_q, done_d;
   logic [RV_ENTRY_SIZE-1:0] done_index_q, done_index_d;
   logic                     ffv_q, ffv_d;
   logic [4:0]               ff_q, ff_d;
   logic                     ovf_q, ovf_d;
   logic                     und_q, und_d;

   tag_t tag_head;
   ent_t buf_head;
   ent_t short_ent;

   logic res_discard, res_pop, res_under;
   logic long_win, buf_pop, short_direct, short_push_req;
   logic buf_full, buf_push, buf_ovf;
   logic tag_full, tag_push_req, tag_push, tag_ovf;

   assign tag_head  = tag_mem_q[tag_rp_q];
   assign buf_head  = buf_mem_q[buf_rp_q];
   assign short_ent = '{wr: i_short_wr, rnid: i_short_rnid,
                        index: i_short_index, data: i_short_data};

   assign tag_full = (tag_cnt_q == LCNT_W'(LONG_DEPTH));
   assign buf_full = (buf_cnt_q == BCNT_W'(BUF_DEPTH));

   // Long result disposition; applies in flush cycles too
   assign res_discard = i_long_res_valid && (disc_q != '0);
   assign res_pop     = i_long_res_valid && (disc_q == '0) && (tag_cnt_q != '0);
   assign res_under   = i_long_res_valid && (disc_q == '0) && (tag_cnt_q == '0);

   // Arbitration: surviving long result, then buffer head, then direct short
   assign long_win       = res_pop && !i_flush;
   assign buf_pop        = !i_flush && !long_win && (buf_cnt_q != '0);
   assign short_push_req = i_short_valid && !i_flush && (long_win || (buf_cnt_q != '0));
   assign short_direct   = i_short_valid && !i_flush && !long_win && (buf_cnt_q == '0);
   assign buf_push       = short_push_req && (!buf_full || buf_pop);
   assign buf_ovf        = short_push_req && buf_full && !buf_pop;

   assign tag_push_req = i_long_issue_valid && !i_flush;
   assign tag_push     = tag_push_req && (!tag_full || res_pop);
   assign tag_ovf      = tag_push_req && tag_full && !res_pop;

   assign o_stall = (buf_cnt_q >= BCNT_W'(BUF_DEPTH - 1)) ||
                    (tag_cnt_q >= LCNT_W'(LONG_DEPTH - 1));

   // Queue pointer/count and discard counter next-state
   always_comb begin
      tag_rp_d  = tag_rp_q;
      tag_wp_d  = tag_wp_q;
      tag_cnt_d = tag_cnt_q;
      buf_rp_d  = buf_rp_q;
      buf_wp_d  = buf_wp_q;
      buf_cnt_d = buf_cnt_q;
      disc_d    = disc_q;
      // Tags still queued at flush become results to drop; a pop this cycle
      // consumes one of them first.
      disc_sum  = {1'b0, disc_q} - (DISC_W+1)'(res_discard)
                  + (DISC_W+1)'(tag_cnt_q) - (DISC_W+1)'(res_pop);
      if (i_flush) begin
         tag_rp_d  = '0;
         tag_wp_d  = '0;
         tag_cnt_d = '0;
         buf_rp_d  = '0;
         buf_wp_d  = '0;
         buf_cnt_d = '0;
         if (disc_sum > (DISC_W+1)'(DISC_MAX)) begin
            disc_d = DISC_W'(DISC_MAX);
         end else begin
            disc_d = disc_sum[DISC_W-1:0];
         end
      end else begin
         disc_d = disc_q - DISC_W'(res_discard);
         if (res_pop)  tag_rp_d = tag_rp_q + LPTR_W'(1);
         if (tag_push) tag_wp_d = tag_wp_q + LPTR_W'(1);
         tag_cnt_d = tag_cnt_q + LCNT_W'(tag_push) - LCNT_W'(res_pop);
         if (buf_pop)  buf_rp_d = buf_rp_q + BPTR_W'(1);
         if (buf_push) buf_wp_d = buf_wp_q + BPTR_W'(1);
         buf_cnt_d = buf_cnt_q + BCNT_W'(buf_push) - BCNT_W'(buf_pop);
      end
   end

   // Output register next-state: winner selection, hold payload when idle
   always_comb begin
      wr_valid_d   = 1'b0;
      done_d       = 1'b0;
      ffv_d        = 1'b0;
      ff_d         = '0;
      wr_rnid_d    = wr_rnid_q;
      wr_data_d    = wr_data_q;
      done_index_d = done_index_q;
      if (long_win) begin
         wr_valid_d   = tag_head.wr;
         wr_rnid_d    = tag_head.rnid;
         wr_data_d    = i_long_res_data;
         done_d       = 1'b1;
         done_index_d = tag_head.index;
         ffv_d        = 1'b1;
         ff_d         = i_long_res_fflags;
      end else if (buf_pop) begin
         wr_valid_d   = buf_head.wr;
         wr_rnid_d    = buf_head.rnid;
         wr_data_d    = buf_head.data;
         done_d       = 1'b1;
         done_index_d = buf_head.index;
      end else if (short_direct) begin
         wr_valid_d   = i_short_wr;
         wr_rnid_d    = i_short_rnid;
         wr_data_d    = i_short_data;
         done_d       = 1'b1;
         done_index_d = i_short_index;
      end
      ovf_d = ovf_q | buf_ovf | tag_ovf;
      und_d = und_q | res_under;
   end

   // Control and output state registers with synchronous reset
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         tag_rp_q     <= '0;
         tag_wp_q     <= '0;
         tag_cnt_q    <= '0;
         buf_rp_q     <= '0;
         buf_wp_q     <= '0;
         buf_cnt_q    <= '0;
         disc_q       <= '0;
         wr_valid_q   <= 1'b0;
         wr_rnid_q    <= '0;
         wr_data_q    <= '0;
         done_q       <= 1'b0;
         done_index_q <= '0;
         ffv_q        <= 1'b0;
         ff_q         <= '0;
         ovf_q        <= 1'b0;
         und_q        <= 1'b0;
      end else begin
         tag_rp_q     <= tag_rp_d;
         tag_wp_q     <= tag_wp_d;
         tag_cnt_q    <= tag_cnt_d;
         buf_rp_q     <= buf_rp_d;
         buf_wp_q     <= buf_wp_d;
         buf_cnt_q    <= buf_cnt_d;
         disc_q       <= disc_d;
         wr_valid_q   <= wr_valid_d;
         wr_rnid_q    <= wr_rnid_d;
         wr_data_q    <= wr_data_d;
         done_q       <= done_d;
         done_index_q <= done_index_d;
         ffv_q        <= ffv_d;
         ff_q         <= ff_d;
         ovf_q        <= ovf_d;
         und_q        <= und_d;
      end
   end

   // FIFO storage writes; a write into a full FIFO with a same-cycle pop
   // lands in the slot being read, whose old value is consumed this cycle.
   always_ff @(posedge i_clk) begin
      if (!i_reset && tag_push) begin
         tag_mem_q[tag_wp_q] <= '{wr: i_long_issue_wr, rnid: i_long_issue_rnid,
                                  index: i_long_issue_index};
      end
      if (!i_reset && buf_push) begin
         buf_mem_q[buf_wp_q] <= short_ent;
      end
   end

   assign o_wr_valid      = wr_valid_q;
   assign o_wr_rnid       = wr_rnid_q;
   assign o_wr_data       = wr_data_q;
   assign o_done          = done_q;
   assign o_done_index    = done_index_q;
   assign o_fflags_valid  = ffv_q;
   assign o_fflags        = ff_q;
   assign o_err_overflow  = ovf_q;
   assign o_err_underflow = und_q;

endmodule

// File: tb/tb_msrh_fpu_wb_merge.sv
// Testbench for msrh_fpu_wb_merge: directed scenarios plus randomized traffic
// checked every cycle against a queue-based model of the merge rules.
module tb_msrh_fpu_wb_merge;

   localparam int unsigned LD = 8;
   localparam int unsigned BD = 4;

   logic        clk;
   logic        i_reset;
   logic        i_short_valid, i_short_wr;
   logic [6:0]  i_short_rnid;
   logic [31:0] i_short_index;
   logic [63:0] i_short_data;
   logic        i_long_issue_valid, i_long_issue_wr;
   logic [6:0]  i_long_issue_rnid;
   logic [31:0] i_long_issue_index;
   logic        i_long_res_valid;
   logic [63:0] i_long_res_data;
   logic [4:0]  i_long_res_fflags;
   logic        i_flush;
   logic        o_stall, o_wr_valid, o_done, o_fflags_valid;
   logic        o_err_overflow, o_err_underflow;
   logic [6:0]  o_wr_rnid;
   logic [63:0] o_wr_data;
   logic [31:0] o_done_index;
   logic [4:0]  o_fflags;

   msrh_fpu_wb_merge #(
      .XLEN(64), .RNID_W(7), .RV_ENTRY_SIZE(32), .LONG_DEPTH(LD), .BUF_DEPTH(BD)
   ) dut (
      .i_clk(clk), .i_reset(i_reset),
      .i_short_valid(i_short_valid), .i_short_wr(i_short_wr),
      .i_short_rnid(i_short_rnid), .i_short_index(i_short_index),
      .i_short_data(i_short_data),
      .i_long_issue_valid(i_long_issue_valid), .i_long_issue_wr(i_long_issue_wr),
      .i_long_issue_rnid(i_long_issue_rnid), .i_long_issue_index(i_long_issue_index),
      .i_long_res_valid(i_long_res_valid), .i_long_res_data(i_long_res_data),
      .i_long_res_fflags(i_long_res_fflags), .i_flush(i_flush),
      .o_stall(o_stall), .o_wr_valid(o_wr_valid), .o_wr_rnid(o_wr_rnid),
      .o_wr_data(o_wr_data), .o_done(o_done), .o_done_index(o_done_index),
      .o_fflags_valid(o_fflags_valid), .o_fflags(o_fflags),
      .o_err_overflow(o_err_overflow), .o_err_underflow(o_err_underflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   typedef struct {
      logic        wr;
      logic [6:0]  rnid;
      logic [31:0] index;
      logic [63:0] data;
   } ent_s;

   ent_s        tq[$];   // queued long tags (data unused)
   ent_s        bq[$];   // waiting short results
   int unsigned disc;
   logic        m_ovf, m_und;
   logic        e_wrv, e_done, e_ffv;
   logic [4:0]  e_ff;
   logic [6:0]  e_rnid;
   logic [63:0] e_data;
   logic [31:0] e_index;

   int unsigned n_cmp = 0;
   int unsigned n_bad = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      tq.delete(); bq.delete();
      disc = 0; m_ovf = 0; m_und = 0;
      e_wrv = 0; e_done = 0; e_ffv = 0; e_ff = '0;
      e_rnid = '0; e_data = '0; e_index = '0;
   endtask

   task automatic emit(input ent_s e, input logic ffv, input logic [4:0] ff);
      e_wrv = e.wr; e_done = 1'b1; e_rnid = e.rnid; e_data = e.data;
      e_index = e.index; e_ffv = ffv; e_ff = ff;
   endtask

   task automatic model_step();
      ent_s h, s;
      bit   win;
      win = 0;
      e_wrv = 0; e_done = 0; e_ffv = 0; e_ff = '0;
      s = '{wr: i_short_wr, rnid: i_short_rnid, index: i_short_index, data: i_short_data};
      if (i_long_res_valid) begin
         if (disc > 0) disc--;
         else if (tq.size() > 0) begin h = tq.pop_front(); win = 1; end
         else m_und = 1;
      end
      if (i_flush) begin
         disc += tq.size();
         if (disc > 2 * LD - 1) disc = 2 * LD - 1;
         tq.delete(); bq.delete();
         return;
      end
      if (i_long_issue_valid) begin
         if (tq.size() < LD)
            tq.push_back('{wr: i_long_issue_wr, rnid: i_long_issue_rnid,
                           index: i_long_issue_index, data: '0});
         else m_ovf = 1;
      end
      if (win) begin
         h.data = i_long_res_data;
         emit(h, 1'b1, i_long_res_fflags);
         if (i_short_valid) begin
            if (bq.size() < BD) bq.push_back(s); else m_ovf = 1;
         end
      end else if (bq.size() > 0) begin
         emit(bq.pop_front(), 1'b0, 5'd0);
         if (i_short_valid) bq.push_back(s);
      end else if (i_short_valid) begin
         emit(s, 1'b0, 5'd0);
      end
   endtask

   // ---------------- stimulus helpers ----------------
   task automatic idle_inputs();
      i_short_valid = 0; i_short_wr = 0; i_short_rnid = '0; i_short_index = '0;
      i_short_data = '0; i_long_issue_valid = 0; i_long_issue_wr = 0;
      i_long_issue_rnid = '0; i_long_issue_index = '0; i_long_res_valid = 0;
      i_long_res_data = '0; i_long_res_fflags = '0; i_flush = 0;
   endtask

   // One clock: stall check before the edge, model step, full compare after.
   task automatic tick();
      logic exp_stall;
      exp_stall = (bq.size() >= BD - 1) || (tq.size() >= LD - 1);
      check("stall", 64'(o_stall), 64'(exp_stall));
      model_step();
      @(posedge clk); #1;
      check("wr_valid", 64'(o_wr_valid), 64'(e_wrv));
      check("done", 64'(o_done), 64'(e_done));
      check("fflags_valid", 64'(o_fflags_valid), 64'(e_ffv));
      check("fflags", 64'(o_fflags), 64'(e_ff));
      if (e_wrv) begin
         check("wr_rnid", 64'(o_wr_rnid), 64'(e_rnid));
         check("wr_data", o_wr_data, e_data);
      end
      if (e_done) check("done_index", 64'(o_done_index), 64'(e_index));
      check("err_overflow", 64'(o_err_overflow), 64'(m_ovf));
      check("err_underflow", 64'(o_err_underflow), 64'(m_und));
      idle_inputs();
   endtask

   task automatic do_reset();
      idle_inputs();
      i_reset = 1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      i_reset = 0;
      model_reset();
      check("rst_wr_valid", 64'(o_wr_valid), 64'd0);
      check("rst_done", 64'(o_done), 64'd0);
      check("rst_wr_data", o_wr_data, 64'd0);
      check("rst_stall", 64'(o_stall), 64'd0);
      check("rst_ovf", 64'(o_err_overflow), 64'd0);
      check("rst_und", 64'(o_err_underflow), 64'd0);
   endtask

   task automatic set_issue(input logic [6:0] rnid, input logic [31:0] idx, input logic wr);
      i_long_issue_valid = 1; i_long_issue_rnid = rnid;
      i_long_issue_index = idx; i_long_issue_wr = wr;
   endtask

   task automatic set_short(input logic [6:0] rnid, input logic [31:0] idx,
                            input logic [63:0] data, input logic wr);
      i_short_valid = 1; i_short_rnid = rnid; i_short_index = idx;
      i_short_data = data; i_short_wr = wr;
   endtask

   task automatic set_res(input logic [63:0] data, input logic [4:0] ff);
      i_long_res_valid = 1; i_long_res_data = data; i_long_res_fflags = ff;
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int unsigned outstanding;
      i_reset = 1;
      idle_inputs();
      model_reset();
      do_reset();

      // Short only
      set_short(7'd5, 32'h4, 64'h3f80_0000, 1'b1);
      tick();
      check("short_rnid", 64'(o_wr_rnid), 64'd5);
      check("short_index", 64'(o_done_index), 64'h4);
      check("short_wrv", 64'(o_wr_valid), 64'd1);
      check("short_ffv", 64'(o_fflags_valid), 64'd0);
      tick();

      // Long pairing
      set_issue(7'd10, 32'h2, 1'b1); tick();
      set_issue(7'd11, 32'h8, 1'b1); tick();
      tick();
      set_res(64'hAA, 5'h1); tick();
      check("long0_rnid", 64'(o_wr_rnid), 64'd10);
      check("long0_data", o_wr_data, 64'hAA);
      check("long0_ff", 64'(o_fflags), 64'h1);
      set_res(64'hBB, 5'h0); tick();
      check("long1_rnid", 64'(o_wr_rnid), 64'd11);
      check("long1_data", o_wr_data, 64'hBB);
      check("long1_index", 64'(o_done_index), 64'h8);
      tick();

      // Collision
      set_issue(7'd20, 32'h10, 1'b1); tick();
      set_res(64'hCC, 5'h2); set_short(7'd3, 32'h1, 64'h33, 1'b1); tick();
      check("col_long", 64'(o_wr_rnid), 64'd20);
      set_short(7'd4, 32'h40, 64'h44, 1'b1); tick();
      check("col_s3", 64'(o_wr_rnid), 64'd3);
      tick();
      check("col_s4", 64'(o_wr_rnid), 64'd4);
      tick();

      // Stall and full
      for (int k = 0; k < 6; k++) begin
         set_issue(7'(30 + k), 32'(1) << k, 1'b1); tick();
      end
      for (int k = 0; k < 5; k++) begin
         set_res(64'(100 + k), 5'd0);
         set_short(7'(50 + k), 32'h100, 64'(200 + k), 1'b1);
         tick();
         if (k == 2) check("stall_at3", 64'(o_stall), 64'd1);
      end
      check("ovf_set", 64'(o_err_overflow), 64'd1);
      for (int k = 0; k < 5; k++) tick();

      // Reset mid-operation, then flush with in-flight ops
      do_reset();
      set_issue(7'd60, 32'h1, 1'b1); tick();
      set_issue(7'd61, 32'h2, 1'b1); tick();
      set_issue(7'd62, 32'h4, 1'b0); tick();
      set_res(64'h600, 5'd3); tick();
      check("fl_first", 64'(o_wr_rnid), 64'd60);
      i_flush = 1; tick();
      set_res(64'h601, 5'd0); tick();
      check("fl_drop1", 64'(o_done), 64'd0);
      set_res(64'h602, 5'd0); tick();
      check("fl_drop2", 64'(o_done), 64'd0);
      check("fl_no_und", 64'(o_err_underflow), 64'd0);
      tick();

      // Underflow
      do_reset();
      set_res(64'h77, 5'd1); tick();
      check("und_set", 64'(o_err_underflow), 64'd1);
      check("und_nodone", 64'(o_done), 64'd0);

      // Randomized traffic with a well-behaved upstream and fpnew
      do_reset();
      outstanding = 0;
      for (int c = 0; c < 2500; c++) begin
         i_flush = ($urandom_range(29) == 0);
         if (outstanding > 0 && $urandom_range(2) != 0) begin
            set_res({$urandom, $urandom}, 5'($urandom_range(31)));
            outstanding--;
         end
         if (!i_flush && !o_stall && outstanding < LD && $urandom_range(2) == 0) begin
            set_issue(7'($urandom_range(127)), 32'(1) << $urandom_range(31),
                      1'($urandom_range(3) != 0));
            outstanding++;
         end
         if (!o_stall && $urandom_range(1) == 0)
            set_short(7'($urandom_range(127)), 32'(1) << $urandom_range(31),
                      {$urandom, $urandom}, 1'($urandom_range(3) != 0));
         tick();
      end
      for (int c = 0; c < 20; c++) begin
         if (outstanding > 0) begin
            set_res({$urandom, $urandom}, 5'($urandom_range(31)));
            outstanding--;
         end
         tick();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
